// File: rtl/gray_frame_ctrl.sv
`timescale 1ns/1ps
// Frame scheduler ahead of the RGB565->gray stage: routes whole frames to gray, bypass or drop.
// Optional stats (err_cnt, last_len) enabled by defining GRAY_FRAME_STAT_EN.
module gray_frame_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_mode,
  input  logic [3:0]       cfg_skip,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic             din_vld,
  input  logic [15:0]      din,
  output logic             cv_sop,
  output logic             cv_eop,
  output logic             cv_vld,
  output logic [15:0]      cv_din,
  output logic             bp_sop,
  output logic             bp_eop,
  output logic             bp_vld,
  output logic [15:0]      bp_dout,
  output logic [1:0]       frame_mode,
  output logic             busy,
  output logic             err_len,
  output logic [15:0]      frame_cnt
`ifdef GRAY_FRAME_STAT_EN
  ,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] last_len
`endif
);

  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(H_ACT * V_ACT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SKIP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       skip_q, skip_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             cv_sop_q, cv_sop_d;
  logic             cv_eop_q, cv_eop_d;
  logic             cv_vld_q, cv_vld_d;
  logic [15:0]      cv_din_q, cv_din_d;
  logic             bp_sop_q, bp_sop_d;
  logic             bp_eop_q, bp_eop_d;
  logic             bp_vld_q, bp_vld_d;
  logic [15:0]      bp_dout_q, bp_dout_d;

  logic fwd, fwd_gray, pass;
  logic beat_sop, beat_run, beat_skp;

`ifdef GRAY_FRAME_STAT_EN
  logic [7:0]       ecnt_q, ecnt_d;
  logic [CNT_W-1:0] llen_q, llen_d;
`endif

  assign beat_sop = din_vld & din_sop;
  assign beat_run = din_vld & ~din_sop & (state_q == RUN);
  assign beat_skp = din_vld & ~din_sop & din_eop & (state_q == SKIP);

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    pix_d    = pix_q;
    mode_d   = mode_q;
    fcnt_d   = fcnt_q;
    err_d    = 1'b0;
    fwd      = 1'b0;
    fwd_gray = mode_q[0];
    pass     = 1'b0;
`ifdef GRAY_FRAME_STAT_EN
    llen_d   = llen_q;
`endif
    unique case (1'b1)
      beat_sop: begin
        // a sop inside RUN truncates the open frame
        if (state_q == RUN) begin
          err_d = 1'b1;
`ifdef GRAY_FRAME_STAT_EN
          llen_d = pix_q;
`endif
        end
        mode_d   = cfg_mode;
        pass     = (skip_q == 4'd0) && !cfg_mode[1];
        skip_d   = (skip_q == 4'd0) ? cfg_skip : skip_q - 4'd1;
        fwd      = pass;
        fwd_gray = cfg_mode[0];
        if (pass) begin
          pix_d = ONE;
          if (din_eop) begin
            state_d = IDLE;
`ifdef GRAY_FRAME_STAT_EN
            llen_d = ONE;
`endif
            if (FRAME_PIX != ONE) err_d = 1'b1;
            else fcnt_d = fcnt_q + 16'd1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = din_eop ? IDLE : SKIP;
        end
      end
      beat_run: begin
        if (din_eop) begin
          fwd     = 1'b1;
          pix_d   = pix_q + ONE;
          state_d = IDLE;
`ifdef GRAY_FRAME_STAT_EN
          llen_d = pix_q + ONE;
`endif
          if (pix_q + ONE != FRAME_PIX) err_d = 1'b1;
          else fcnt_d = fcnt_q + 16'd1;
        end else if (pix_q == FRAME_PIX) begin
          err_d   = 1'b1;
          state_d = SKIP;
        end else begin
          fwd   = 1'b1;
          pix_d = pix_q + ONE;
        end
      end
      beat_skp: state_d = IDLE;
      default: ;
    endcase

    busy_d    = (state_d == RUN);
    cv_vld_d  = fwd & fwd_gray;
    cv_sop_d  = cv_vld_d & din_sop;
    cv_eop_d  = cv_vld_d & din_eop;
    cv_din_d  = cv_vld_d ? din : cv_din_q;
    bp_vld_d  = fwd & ~fwd_gray;
    bp_sop_d  = bp_vld_d & din_sop;
    bp_eop_d  = bp_vld_d & din_eop;
    bp_dout_d = bp_vld_d ? din : bp_dout_q;
`ifdef GRAY_FRAME_STAT_EN
    ecnt_d = (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      skip_q    <= '0;
      pix_q     <= '0;
      mode_q    <= '0;
      fcnt_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cv_sop_q  <= 1'b0;
      cv_eop_q  <= 1'b0;
      cv_vld_q  <= 1'b0;
      cv_din_q  <= '0;
      bp_sop_q  <= 1'b0;
      bp_eop_q  <= 1'b0;
      bp_vld_q  <= 1'b0;
      bp_dout_q <= '0;
`ifdef GRAY_FRAME_STAT_EN
      ecnt_q    <= '0;
      llen_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      pix_q     <= pix_d;
      mode_q    <= mode_d;
      fcnt_q    <= fcnt_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      cv_sop_q  <= cv_sop_d;
      cv_eop_q  <= cv_eop_d;
      cv_vld_q  <= cv_vld_d;
      cv_din_q  <= cv_din_d;
      bp_sop_q  <= bp_sop_d;
      bp_eop_q  <= bp_eop_d;
      bp_vld_q  <= bp_vld_d;
      bp_dout_q <= bp_dout_d;
`ifdef GRAY_FRAME_STAT_EN
      ecnt_q    <= ecnt_d;
      llen_q    <= llen_d;
`endif
    end
  end

  assign cv_sop     = cv_sop_q;
  assign cv_eop     = cv_eop_q;
  assign cv_vld     = cv_vld_q;
  assign cv_din     = cv_din_q;
  assign bp_sop     = bp_sop_q;
  assign bp_eop     = bp_eop_q;
  assign bp_vld     = bp_vld_q;
  assign bp_dout    = bp_dout_q;
  assign frame_mode = mode_q;
  assign busy       = busy_q;
  assign err_len    = err_q;
  assign frame_cnt  = fcnt_q;
`ifdef GRAY_FRAME_STAT_EN
  assign err_cnt    = ecnt_q;
  assign last_len   = llen_q;
`endif

endmodule

// File: tb/tb_gray_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for gray_frame_ctrl with a small 4x2 frame.
// Frame-level reference model; IDLE and SKIP are indistinguishable externally.
module tb_gray_frame_ctrl;

  localparam int FP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_skip = '0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;
  logic        din_vld = 1'b0;
  logic [15:0] din = '0;
  logic        cv_sop, cv_eop, cv_vld;
  logic [15:0] cv_din;
  logic        bp_sop, bp_eop, bp_vld;
  logic [15:0] bp_dout;
  logic [1:0]  frame_mode;
  logic        busy, err_len;
  logic [15:0] frame_cnt;
`ifdef GRAY_FRAME_STAT_EN
  logic [7:0]  err_cnt;
  logic [19:0] last_len;
`endif

  always #5 clk = ~clk;

  gray_frame_ctrl #(.H_ACT(4), .V_ACT(2), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_mode(cfg_mode), .cfg_skip(cfg_skip),
    .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld), .din(din),
    .cv_sop(cv_sop), .cv_eop(cv_eop), .cv_vld(cv_vld), .cv_din(cv_din),
    .bp_sop(bp_sop), .bp_eop(bp_eop), .bp_vld(bp_vld), .bp_dout(bp_dout),
    .frame_mode(frame_mode), .busy(busy), .err_len(err_len),
    .frame_cnt(frame_cnt)
`ifdef GRAY_FRAME_STAT_EN
    , .err_cnt(err_cnt), .last_len(last_len)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_fwd;
  int          m_len;
  int          m_skip;
  logic [1:0]  m_mode;
  logic [15:0] m_fcnt;
  logic        e_cvs, e_cve, e_cvv, e_bps, e_bpe, e_bpv, e_err;
  logic [15:0] e_cvd, e_bpd;

  function automatic logic [57:0] outs();
    return {cv_sop, cv_eop, cv_vld, cv_din, bp_sop, bp_eop, bp_vld,
            bp_dout, frame_mode, busy, err_len, frame_cnt};
  endfunction

  function automatic logic [57:0] expv();
    return {e_cvs, e_cve, e_cvv, e_cvd, e_bps, e_bpe, e_bpv, e_bpd,
            m_mode, logic'(m_fwd), e_err, m_fcnt};
  endfunction

  task automatic model_reset();
    m_fwd = 0; m_len = 0; m_skip = 0; m_mode = '0; m_fcnt = '0;
    e_cvs = 0; e_cve = 0; e_cvv = 0; e_cvd = '0;
    e_bps = 0; e_bpe = 0; e_bpv = 0; e_bpd = '0; e_err = 0;
  endtask

  task automatic emit(input logic s, input logic e, input logic [15:0] d);
    if (m_mode == 2'd1) begin
      e_cvv = 1; e_cvs = s; e_cve = e; e_cvd = d;
    end else begin
      e_bpv = 1; e_bps = s; e_bpe = e; e_bpd = d;
    end
  endtask

  task automatic close_frame();
    if (m_len != FP) e_err = 1;
    else m_fcnt = m_fcnt + 16'd1;
    m_fwd = 0;
  endtask

  task automatic model_beat(input logic v, input logic s, input logic e,
                            input logic [15:0] d);
    bit pass;
    e_cvv = 0; e_cvs = 0; e_cve = 0;
    e_bpv = 0; e_bps = 0; e_bpe = 0; e_err = 0;
    if (v) begin
      if (s) begin
        if (m_fwd) e_err = 1;
        m_fwd  = 0;
        m_mode = cfg_mode;
        pass   = (m_skip == 0) && (cfg_mode < 2);
        m_skip = (m_skip == 0) ? int'(cfg_skip) : m_skip - 1;
        if (pass) begin
          emit(s, e, d);
          m_len = 1;
          if (e) close_frame();
          else m_fwd = 1;
        end
      end else if (m_fwd) begin
        if (e) begin
          emit(s, e, d);
          m_len++;
          close_frame();
        end else if (m_len == FP) begin
          e_err = 1;
          m_fwd = 0;
        end else begin
          emit(s, e, d);
          m_len++;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e);
    logic [15:0] d;
    d = 16'($urandom);
    din_vld = v; din_sop = s; din_eop = e; din = d;
    model_beat(v, s, e, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_vld = 0; din_sop = 0; din_eop = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    din_vld = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== 58'd0) begin
      errors++;
      $display("FAIL reset got %h exp 0", outs());
    end
    rst_n = 1;
  endtask

  task automatic test_gray_b2b();
    bit bp_seen = 0;
    do_reset();
    cfg_mode = 2'd1; cfg_skip = 4'd0;
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= FP; i++) begin
        step(1, i == 1, i == FP);
        if (bp_vld || err_len) bp_seen = 1;
        checks++;
        if (outs() !== expv()) begin
          errors++;
          $display("FAIL gray_b2b f%0d b%0d got %h exp %h", f, i, outs(), expv());
        end
      end
    step(0, 0, 0);
    checks++;
    if (frame_cnt !== 16'd2 || bp_seen) begin
      errors++;
      $display("FAIL gray_b2b_cnt got %0d/%0b exp 2/0", frame_cnt, bp_seen);
    end
  endtask

  task automatic test_decimate();
    logic [5:0] mask = '0;
    do_reset();
    cfg_mode = 2'd0; cfg_skip = 4'd2;
    for (int f = 0; f < 6; f++)
      for (int i = 1; i <= FP; i++) begin
        step(1, i == 1, i == FP);
        if (bp_vld) mask[f] = 1'b1;
        checks++;
        if (outs() !== expv()) begin
          errors++;
          $display("FAIL decimate f%0d b%0d got %h exp %h", f, i, outs(), expv());
        end
      end
    checks++;
    if (mask !== 6'b001001 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL decimate_mask got %b/%0d exp 001001/2", mask, frame_cnt);
    end
  endtask

  task automatic test_short();
    int errs = 0;
    do_reset();
    cfg_mode = 2'd1; cfg_skip = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      step(1, i == 1, i == 6);
      if (err_len) errs++;
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL short b%0d got %h exp %h", i, outs(), expv());
      end
    end
    checks++;
    if (!err_len || errs != 1 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL short_err got %0b/%0d/%0d exp 1/1/0", err_len, errs, frame_cnt);
    end
    for (int i = 1; i <= FP; i++) begin
      step(1, i == 1, i == FP);
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL short_next b%0d got %h exp %h", i, outs(), expv());
      end
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL short_cnt got %0d exp 1", frame_cnt);
    end
  endtask

  task automatic test_overrun();
    int nv = 0, ne = 0, err_at = 0;
    do_reset();
    cfg_mode = 2'd1; cfg_skip = 4'd0;
    for (int i = 1; i <= 10; i++) begin
      step(1, i == 1, i == 10);
      if (cv_vld) nv++;
      if (cv_eop) ne++;
      if (err_len) err_at = err_at * 16 + i;
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL overrun b%0d got %h exp %h", i, outs(), expv());
      end
    end
    checks++;
    if (nv != 8 || ne != 0 || err_at != 9) begin
      errors++;
      $display("FAIL overrun_sum got %0d/%0d/%0d exp 8/0/9", nv, ne, err_at);
    end
    for (int i = 1; i <= FP; i++) begin
      step(1, i == 1, i == FP);
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL overrun_next b%0d got %h exp %h", i, outs(), expv());
      end
    end
  endtask

  task automatic test_mode_switch();
    int ncv = 0, nbp = 0;
    do_reset();
    cfg_mode = 2'd1; cfg_skip = 4'd0;
    for (int i = 1; i <= FP; i++) begin
      if (i == 4) cfg_mode = 2'd0;
      step(1, i == 1, i == FP);
      if (cv_vld && frame_mode == 2'd1) ncv++;
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL mode_sw b%0d got %h exp %h", i, outs(), expv());
      end
    end
    for (int i = 1; i <= FP; i++) begin
      step(1, i == 1, i == FP);
      if (bp_vld && frame_mode == 2'd0) nbp++;
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL mode_sw2 b%0d got %h exp %h", i, outs(), expv());
      end
    end
    checks++;
    if (ncv != 8 || nbp != 8) begin
      errors++;
      $display("FAIL mode_sw_cnt got %0d/%0d exp 8/8", ncv, nbp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_mode = 2'd1; cfg_skip = 4'd0;
    for (int i = 1; i <= 4; i++) step(1, i == 1, 1'b0);
    din_vld = 1; din_sop = 0; din_eop = 0;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (outs() !== 58'd0) begin
      errors++;
      $display("FAIL reset_mid_async got %h exp 0", outs());
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== 58'd0) begin
      errors++;
      $display("FAIL reset_mid_hold got %h exp 0", outs());
    end
    rst_n = 1;
    for (int i = 6; i <= FP; i++) begin
      step(1, 1'b0, i == FP);
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL reset_mid_drop b%0d got %h exp %h", i, outs(), expv());
      end
    end
    for (int i = 1; i <= FP; i++) begin
      step(1, i == 1, i == FP);
      checks++;
      if (outs() !== expv()) begin
        errors++;
        $display("FAIL reset_mid_next b%0d got %h exp %h", i, outs(), expv());
      end
    end
  endtask

  task automatic test_random();
    int len;
    bit has_eop;
    do_reset();
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_mode = ($urandom_range(0, 5) == 0) ? 2'(2 + $urandom_range(0, 1))
                                                : 2'($urandom_range(0, 1));
        cfg_skip = 4'($urandom_range(0, 2));
      end
      len = (f % 3 == 0) ? FP : $urandom_range(1, 10);
      has_eop = $urandom_range(0, 4) != 0;
      for (int i = 1; i <= len; i++) begin
        if ($urandom_range(0, 9) == 0) cfg_mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) begin
          step(0, 1'($urandom), 1'($urandom));
          checks++;
          if (outs() !== expv()) begin
            errors++;
            $display("FAIL random_gap f%0d got %h exp %h", f, outs(), expv());
          end
        end
        step(1, i == 1, has_eop && i == len);
        checks++;
        if (outs() !== expv()) begin
          errors++;
          $display("FAIL random f%0d b%0d got %h exp %h", f, i, outs(), expv());
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        step(1, 1'b0, 1'($urandom));
        checks++;
        if (outs() !== expv()) begin
          errors++;
          $display("FAIL random_stray f%0d got %h exp %h", f, outs(), expv());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_gray_b2b();
    test_decimate();
    test_short();
    test_overrun();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_frame_ctrl.md
Name: gray_frame_ctrl

Overview:
- Frame-level scheduler in front of the RGB565→gray converter on the CMOS→SDRAM→VGA path.
- Takes the raw camera pixel stream (sop/eop/vld + RGB565) and steers each whole frame to one of three destinations: the gray conversion stage, the RGB565 bypass path, or drop.
- Configuration is sampled only at frame start. Frame decimation, frame-length checking and resync after malformed frames are enforced here, so the downstream converter only ever sees well-bounded frames.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame; FRAME_PIX = H_ACT*V_ACT.
- CNT_W, 20, pixel counter width; must satisfy 2^CNT_W > FRAME_PIX.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  2  0=RGB bypass, 1=gray, 2/3=off (drop all)
- cfg_skip  in  4  forward 1 frame of every cfg_skip+1
- din_sop  in  1  first pixel of frame, qualified by din_vld
- din_eop  in  1  last pixel of frame, qualified by din_vld
- din_vld  in  1  pixel valid
- din  in  16  RGB565 pixel
- cv_sop / cv_eop / cv_vld  out  1 each  stream to gray converter
- cv_din  out  16  pixel to gray converter
- bp_sop / bp_eop / bp_vld  out  1 each  RGB bypass stream
- bp_dout  out  16  bypass pixel
- frame_mode  out  2  mode latched for the current/last frame
- busy  out  1  high while in RUN
- err_len  out  1  one-cycle pulse on frame length error
- frame_cnt  out  16  count of frames forwarded completely, wraps

Behaviour:
- Reset values: all outputs 0; state IDLE; skip_cnt=0; pix_cnt=0. Reset mid-frame aborts the frame immediately with no eop emitted.
- Every output is registered. Latency is exactly 1 cycle from din_* to cv_*/bp_*. Data outputs hold their last value when vld=0.
- A beat is a cycle with din_vld=1. sop/eop without din_vld are ignored.
- States: IDLE, RUN, SKIP.
- IDLE:
  - Non-sop beats are dropped.
  - On a sop beat: latch cfg_mode→frame_mode and evaluate skip.
  - Skip evaluation: pass = (skip_cnt==0) && (cfg_mode<2). Then skip_cnt := (skip_cnt==0) ? cfg_skip : skip_cnt-1.
  - pass=1: go to RUN, forward the beat, pix_cnt:=1. pass=0: go to SKIP.
- RUN:
  - Each beat is forwarded on the path selected by frame_mode (cv_* for gray, bp_* for bypass). sop/eop are copied through. The other path stays idle. pix_cnt increments.
  - eop beat: forward it. If pix_cnt+1 != FRAME_PIX, pulse err_len. Otherwise frame_cnt++. Go to IDLE.
  - sop beat without a preceding eop (truncated frame): pulse err_len, do not increment frame_cnt, and treat the beat as an IDLE sop in the same cycle (re-latch mode, re-evaluate skip). The previous frame ends without an output eop.
  - Non-eop beat when pix_cnt==FRAME_PIX (overrun): drop the beat, pulse err_len, go to SKIP.
- SKIP:
  - All beats are dropped.
  - eop beat → IDLE.
  - sop beat → handled as an IDLE sop in the same cycle.
- A beat with sop and eop both set in IDLE is a 1-pixel frame: forwarded if pass=1, length checked against 1, ends in IDLE.
- Changes to cfg_mode or cfg_skip mid-frame have no effect until the next sop. frame_mode stays constant from sop through eop.
- Simultaneous err_len causes on one beat produce a single pulse. frame_cnt wraps 0xFFFF→0.
- busy = (state==RUN), registered.

Optional Feature:
- Macro GRAY_FRAME_STAT_EN.
- When defined, adds two outputs:
  - err_cnt [7:0]: saturating count of err_len pulses; saturates at 0xFF; cleared only by reset.
  - last_len [CNT_W-1:0]: pixel count of the most recent forwarded frame, updated at its eop beat or truncating sop.
- When undefined, these ports and registers are absent and all other behaviour is identical.

Test Plan (H_ACT=4, V_ACT=2, FRAME_PIX=8):
- cfg_mode=1, cfg_skip=0; two back-to-back 8-beat frames → cv_* carries both frames 1 cycle delayed with sop/eop aligned, bp_vld never 1, frame_cnt=2, err_len never 1.
- cfg_mode=0, cfg_skip=2; six frames → frames 1 and 4 appear on bp_*, frames 2,3,5,6 dropped, frame_cnt=2.
- Gray mode; frame with eop on beat 6 → err_len one pulse 1 cycle after the eop beat, frame_cnt unchanged; next good frame is forwarded normally.
- Gray mode; 10 beats, eop on beat 10 → beats 1–8 forwarded without eop, err_len pulses on beat 9, beats 9–10 dropped, next sop accepted.
- cfg_mode switched 1→0 at beat 4 of a gray frame → remainder stays on cv_* with frame_mode=1; next frame goes to bp_* with frame_mode=0.
- rst_n asserted at beat 5 of a frame, released, then a mid-frame beat with no sop arrives → all outputs 0 during reset, post-reset non-sop beats dropped, first output beat is the next sop.
